// File: rtl/shift_register_sipo_rx.sv
// Serial-in receiver: assembles WIDTH-bit words and holds them behind a valid/ready handshake.
// Optional trailing even-parity bit when SHIFT_REGISTER_SIPO_PARITY_EN is defined.
module shift_register_sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift,
  input  logic                       d_in,
  input  logic                       clr,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic                       parity_err,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_REGISTER_SIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word_next;
  logic             take;
  logic             last;
  logic             slot_free;
  logic             accept;

  assign take      = shift && !clr;
  assign last      = take && (bit_cnt == LAST_CNT);
  assign slot_free = !out_valid || out_ready;
  assign accept    = out_valid && out_ready;

  always_comb begin
    sr_shift = sr;
    if (MSB_FIRST) begin
      sr_shift = {sr[WIDTH-2:0], d_in};
    end else begin
      sr_shift = {d_in, sr[WIDTH-1:1]};
    end
  end

`ifdef SHIFT_REGISTER_SIPO_PARITY_EN
  // The final bit is parity, so the word is already complete in sr.
  assign word_next = sr;
`else
  assign word_next = sr_shift;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (take) begin
      bit_cnt <= last ? '0 : bit_cnt + 1'b1;
`ifdef SHIFT_REGISTER_SIPO_PARITY_EN
      if (!last) begin
        sr <= sr_shift;
      end
`else
      sr <= sr_shift;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b0;
      end
      if (last) begin
        if (slot_free) begin
          data_out  <= word_next;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifdef SHIFT_REGISTER_SIPO_PARITY_EN
  logic par_bad;

  assign par_bad = (^sr) ^ d_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else if (last && par_bad) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
